// File: rtl/mac_requant_relu.sv
// mac_requant_relu: post-MAC stage. Adds bias, rounds and arithmetic-shifts
// the sum, applies ReLU with unsigned saturation to an activation, and buffers
// the results in a small FIFO. Upstream is throttled by credit, so the pipeline
// never stalls and no data is dropped.
module mac_requant_relu #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mac_valid_i,
  input  logic [IN_WIDTH-1:0]  mac_data_i,
  input  logic [IN_WIDTH-1:0]  bias_i,
  output logic                 mac_ready_o,
  output logic                 act_valid_o,
  output logic [OUT_WIDTH-1:0] act_data_o,
  input  logic                 act_ready_i,
  input  logic                 sat_clr_i,
  output logic [CNT_WIDTH-1:0] sat_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);  // pointer width
  localparam int CW = AW + 1;              // occupancy count width
  localparam int SW = IN_WIDTH + 1;        // bias-add result width
  localparam int RW = IN_WIDTH + 2;        // rounding/shift width

  // Half-LSB rounding constant; zero when there is no shift.
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND =
    (SHIFT > 0) ? (RW'(1) << RND_POS) : '0;
  localparam logic signed [RW-1:0] ACT_MAX =
    {{(RW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  // ---------------------------------------------------------------------------
  // Stage 1: bias addition
  // ---------------------------------------------------------------------------
  logic                 accept;
  logic                 s1_valid_q;
  logic signed [SW-1:0] s1_sum_d;
  logic signed [SW-1:0] s1_sum_q;

  assign accept = mac_valid_i && mac_ready_o;

  // Sign-extend both operands by one bit so the sum can never wrap.
  always_comb begin
    s1_sum_d = $signed({mac_data_i[IN_WIDTH-1], mac_data_i}) +
               $signed({bias_i[IN_WIDTH-1], bias_i});
  end

  // Stage 1 register: captures the sum of every accepted MAC result.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) s1_sum_q <= s1_sum_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: round, shift, ReLU, saturate
  // ---------------------------------------------------------------------------
  logic signed [RW-1:0]  sum_ext;
  logic signed [RW-1:0]  rounded;
  logic signed [RW-1:0]  shifted;
  logic [OUT_WIDTH-1:0]  s2_act_d;
  logic                  s2_sat_d;
  logic                  s2_valid_q;
  logic [OUT_WIDTH-1:0]  s2_act_q;
  logic                  s2_sat_q;

  // Requantise: negative results clip to zero silently, large ones clip to the
  // activation maximum and raise the saturation flag.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    sum_ext  = {s1_sum_q[SW-1], s1_sum_q};
    rounded  = sum_ext + RND;
    shifted  = rounded >>> SHIFT;
    s2_act_d = '0;
    s2_sat_d = 1'b0;
    if (shifted[RW-1]) begin
      s2_act_d = '0;
    end else if (shifted > ACT_MAX) begin
      s2_act_d = '1;
      s2_sat_d = 1'b1;
    end else begin
      s2_act_d = shifted[OUT_WIDTH-1:0];
    end
  end

  // Stage 2 register: always advances from stage 1, never stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_act_q   <= '0;
      s2_sat_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_act_q <= s2_act_d;
        s2_sat_q <= s2_sat_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;

  assign push      = s2_valid_q;
  assign pop       = act_valid_o && act_ready_i;
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));

  // Storage array: written from stage 2, read at the head.
  // NOTE: the storage array is deliberately not reset; occupancy tracking makes
  // its contents irrelevant until written, and an empty FIFO drives zero out.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s2_act_q;
  end

  // Occupancy: push and pop in the same cycle leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign act_valid_o = (count_q != '0);
  assign act_data_o  = act_valid_o ? mem_q[rd_ptr_q] : '0;

  // ---------------------------------------------------------------------------
  // Credit: everything in flight or buffered must fit in the FIFO. A pop only
  // frees credit the following cycle, keeping mac_ready_o off the act_ready_i
  // path.
  // ---------------------------------------------------------------------------
  logic [CW:0] in_flight;

  always_comb begin
    in_flight = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q} +
                {{CW{1'b0}}, s2_valid_q};
  end

  assign mac_ready_o = (in_flight < (CW+1)'(FIFO_DEPTH));

  // ---------------------------------------------------------------------------
  // Saturation event counter
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] sat_count_q;

  // Counts high-side clips as they enter the FIFO; sticks at all-ones and a
  // clear request beats a simultaneous increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_count_q <= '0;
    end else if (sat_clr_i) begin
      sat_count_q <= '0;
    end else if (push && s2_sat_q && (sat_count_q != '1)) begin
      sat_count_q <= sat_count_q + CNT_WIDTH'(1);
    end
  end

  assign sat_count_o = sat_count_q;

  // Credit accounting guarantees a push never lands on a full FIFO.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_full));

endmodule
